// File: rtl/divisor_secuencial.sv
// Iterative restoring divider, one quotient bit per clock, start/ready/done.
// Define DIVISOR_SIGNED_EN for two's-complement operands and results.
module divisor_secuencial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_zero
);

    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        CALC = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [N-1:0]  p;
    logic [N-1:0]  dq;
    logic [N-1:0]  dvs;

    logic [N:0]    s;
    logic [N:0]    d;
    logic          q_bit;
    logic [N-1:0]  p_nxt;
    logic [N-1:0]  q_nxt;
    logic [N-1:0]  res_q;
    logic [N-1:0]  res_r;
    logic [N-1:0]  a_cap;
    logic [N-1:0]  b_cap;

    // The partial remainder never reaches B, so N bits hold it; quotient
    // bits shift into the dividend register as its bits are consumed.
    always_comb begin
        s     = {p, dq[N-1]};
        d     = s - {1'b0, dvs};
        q_bit = ~d[N];
        p_nxt = q_bit ? d[N-1:0] : s[N-1:0];
        q_nxt = {dq[N-2:0], q_bit};
    end

`ifdef DIVISOR_SIGNED_EN
    logic q_neg;
    logic r_neg;

    always_comb begin
        a_cap = A[N-1] ? -A : A;
        b_cap = B[N-1] ? -B : B;
        res_q = q_neg ? -q_nxt : q_nxt;
        res_r = r_neg ? -p_nxt : p_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE && start) begin
            q_neg <= A[N-1] ^ B[N-1];
            r_neg <= A[N-1];
        end
    end
`else
    always_comb begin
        a_cap = A;
        b_cap = B;
        res_q = q_nxt;
        res_r = p_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
            count    <= '0;
            p        <= '0;
            dq       <= '0;
            dvs      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        p     <= '0;
                        dq    <= a_cap;
                        dvs   <= b_cap;
                        ready <= 1'b0;
                        if (B == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            Q        <= '1;
                            R        <= A;
                            div_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            count <= CW'(N - 1);
                        end
                    end
                end
                CALC: begin
                    p  <= p_nxt;
                    dq <= q_nxt;
                    if (count == '0) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        Q        <= res_q;
                        R        <= res_r;
                        div_zero <= 1'b0;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Scoreboard bench for divisor_secuencial: driver queues expected results,
// monitor pops and compares on every done pulse.
module tb_divisor_secuencial;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         ready;
    logic         done;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         div_zero;

    divisor_secuencial #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .ready    (ready),
        .done     (done),
        .Q        (Q),
        .R        (R),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a,
                                   input logic [N-1:0] b);
        exp_t e;
        e.due = 0;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
`ifdef DIVISOR_SIGNED_EN
            int sa;
            int sb;
            sa   = int'($signed(a));
            sb   = int'($signed(b));
            e.q  = N'(sa / sb);
            e.r  = N'(sa % sb);
`else
            e.q  = a / b;
            e.r  = a % b;
`endif
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // monitor
    initial begin
        logic         prev_done;
        logic [N-1:0] pq;
        logic [N-1:0] pr;
        logic         pdz;
        exp_t         e;
        prev_done = 1'b0;
        pq = '0;
        pr = '0;
        pdz = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 1'b0;
                pq = '0;
                pr = '0;
                pdz = 1'b0;
            end else begin
                if (prev_done)
                    chk("ready_after_done", ready, 1);
                if (done) begin
                    chk("done_one_cycle", prev_done, 0);
                    chk("ready_low_in_done", ready, 0);
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done: got done=1 expected none (cycle %0d)", cyc);
                    end else begin
                        e = sbq.pop_front();
                        chk("quotient", Q, e.q);
                        chk("remainder", R, e.r);
                        chk("div_zero", div_zero, e.dz);
                        chk("latency_cycle", cyc, e.due);
                    end
                end else begin
                    checks++;
                    if (Q !== pq || R !== pr || div_zero !== pdz) begin
                        errors++;
                        $display("FAIL result_stable: got %0h/%0h/%0b expected %0h/%0h/%0b",
                                 Q, R, div_zero, pq, pr, pdz);
                    end
                end
                prev_done = done;
                pq = Q;
                pr = R;
                pdz = div_zero;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b expected 1", ready);
        end
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit hold);
        exp_t e;
        wait_ready();
        e = model(a, b);
        e.due = cyc + 1 + ((b == 0) ? 0 : N);
        sbq.push_back(e);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        chk("ready_drop", ready, 0);
        if (!hold) begin
            start = 1'b0;
            A = N'($urandom);
            B = N'($urandom);
        end
    endtask

    initial begin
        int n;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_q", Q, 0);
        chk("rst_r", R, 0);
        chk("rst_dz", div_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'd200, 8'd7, 1'b0);
        issue(8'd5, 8'd0, 1'b0);
        issue(8'd3, 8'd9, 1'b0);
        issue(8'd255, 8'd1, 1'b0);
        issue(8'd0, 8'd13, 1'b0);
        issue(8'd77, 8'd77, 1'b0);

        // start stays high while busy; mid-CALC operands must be ignored
        issue(8'd100, 8'd9, 1'b1);
        repeat (3) @(negedge clk);
        A = 8'd50;
        B = 8'd5;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("held_done_seen", done, 1);
        start = 1'b0;
        repeat (6) @(negedge clk);

        // reset during the 4th CALC cycle aborts without a done
        wait_ready();
        A = 8'd200;
        B = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_q", Q, 0);
        chk("abort_r", R, 0);
        chk("abort_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(8'd9, 8'd4, 1'b0);

`ifdef DIVISOR_SIGNED_EN
        issue(8'hF9, 8'h02, 1'b0);
        issue(8'h07, 8'hFE, 1'b0);
        issue(8'h80, 8'hFF, 1'b0);
        issue(8'h80, 8'h00, 1'b0);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = N'($urandom);
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = N'($urandom_range(1, 3));
                default: rb = N'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(ra, rb, 1'b0);
        end

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
